aes_stream_ctrl: RTL and testbench

AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

---
 rtl/aes_stream_pkg.sv | 19 +
 rtl/aes_blk_pack.sv | 51 +++++
 rtl/aes_stream_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_aes_stream_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg
// Shared definitions for the AES stream controller: the 128-bit AES block
// width and the controller state encoding.
package aes_stream_pkg;

   localparam int BLK_W = 128;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_KEY_INIT = 3'd1,
      S_KEY_WAIT = 3'd2,
      S_RD       = 3'd3,
      S_ENC      = 3'd4,
      S_ENC_WAIT = 3'd5,
      S_WR       = 3'd6,
      S_DONE     = 3'd7
   } aes_state_t;

endpackage

// File: rtl/aes_blk_pack.sv
// aes_blk_pack
// Block buffer that converts between BUS_W-bit memory words and one 128-bit
// AES block. Word 0 is the most-significant word of the block. The same
// register gathers read words, receives the cipher result and then feeds
// write words out.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_load/i_load_blk  parallel load of a whole block (cipher result)
//   i_shift_in/i_word_in  append one read word at the bottom
//   i_shift_out        drop the top word after it was written
//   o_word_out         current top word (next word to write)
//   o_blk              whole block
module aes_blk_pack
   import aes_stream_pkg::*;
#(
   parameter int BUS_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [BLK_W-1:0] i_load_blk,
   input  logic             i_shift_in,
   input  logic [BUS_W-1:0] i_word_in,
   input  logic             i_shift_out,
   output logic [BUS_W-1:0] o_word_out,
   output logic [BLK_W-1:0] o_blk
);

   logic [BLK_W-1:0] r_blk;
   logic [BLK_W-1:0] w_word_ext;

   assign w_word_ext = BLK_W'(i_word_in);

   // Words enter at the bottom, so after all of them the first sits on top.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_blk <= '0;
      end else if (i_load) begin
         r_blk <= i_load_blk;
      end else if (i_shift_in) begin
         r_blk <= (r_blk << BUS_W) | w_word_ext;
      end else if (i_shift_out) begin
         r_blk <= r_blk << BUS_W;
      end
   end

   assign o_word_out = r_blk[BLK_W-1 -: BUS_W];
   assign o_blk      = r_blk;

endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl
// Streams num_blocks 128-bit blocks from memory through an external aes_core
// and writes the results back. ECB by default; CBC chaining is built only
// when the macro AES_STREAM_CBC_EN is defined (otherwise mode and iv are
// ignored).
//
// Ports
//   aes_clk, aes_rst                     clock, synchronous active-high reset
//   start, num_blocks, rd/wr_addr_start, mode, iv   job setup, latched at start
//   mem_rd_*                             read request/ack handshake
//   mem_wr_*                             write request/ack handshake
//   core_init, core_next, core_ready, core_block, core_result   aes_core link
//   busy, done, blocks_done, last_result status
//
// state      | meaning
// S_IDLE     | waiting for start
// S_KEY_INIT | waiting for core_ready, then pulse core_init
// S_KEY_WAIT | key expansion running
// S_RD       | reading WPB words of the current block
// S_ENC      | pulse core_next with the (chained) block
// S_ENC_WAIT | waiting for the cipher result
// S_WR       | writing WPB result words
// S_DONE     | one-cycle done pulse
module aes_stream_ctrl
   import aes_stream_pkg::*;
#(
   parameter int BUS_W  = 32,
   parameter int CNT_W  = 32,
   parameter int ADDR_W = 32
) (
   input  logic              aes_clk,
   input  logic              aes_rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_blocks,
   input  logic [ADDR_W-1:0] rd_addr_start,
   input  logic [ADDR_W-1:0] wr_addr_start,
   input  logic              mode,
   input  logic [127:0]      iv,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [BUS_W-1:0]  mem_rd_data,
   input  logic              mem_rd_ack,
   output logic              mem_wr_req,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [BUS_W-1:0]  mem_wr_data,
   input  logic              mem_wr_ack,
   output logic              core_init,
   output logic              core_next,
   input  logic              core_ready,
   output logic [127:0]      core_block,
   input  logic [127:0]      core_result,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  blocks_done,
   output logic [127:0]      last_result
);

   localparam int WPB   = BLK_W / BUS_W;
   localparam int BYTES = BUS_W / 8;

   aes_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_num_blocks, r_blocks_done, w_blk_inc;
   logic [ADDR_W-1:0] r_rd_base, r_wr_base, r_rd_off, r_wr_off;
   logic [1:0]        r_word;
   logic              r_gap, r_pulse_old;
   logic [127:0]      r_last_result;
   logic              w_start, w_rd_acc, w_wr_acc, w_capture, w_last_word;
   logic [BLK_W-1:0]  w_blk;

   assign w_blk_inc   = r_blocks_done + CNT_W'(1);
   assign w_last_word = (r_word == 2'(WPB - 1));

   always_ff @(posedge aes_clk) begin
      if (aes_rst) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // r_gap forces req low for the cycle after an accepted ack; r_pulse_old
   // keeps the core waits from exiting in the cycle right after a pulse.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b1;
      done        = 1'b0;
      core_init   = 1'b0;
      core_next   = 1'b0;
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      w_start     = 1'b0;
      w_rd_acc    = 1'b0;
      w_wr_acc    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_start     = 1'b1;
               w_state_nxt = (num_blocks == '0) ? S_DONE : S_KEY_INIT;
            end
         end
         S_KEY_INIT: begin
            if (core_ready) begin
               core_init   = 1'b1;
               w_state_nxt = S_KEY_WAIT;
            end
         end
         S_KEY_WAIT: begin
            if (core_ready && r_pulse_old) w_state_nxt = S_RD;
         end
         S_RD: begin
            mem_rd_req = !r_gap;
            if (mem_rd_ack && !r_gap) begin
               w_rd_acc = 1'b1;
               if (w_last_word) w_state_nxt = S_ENC;
            end
         end
         S_ENC: begin
            core_next   = 1'b1;
            w_state_nxt = S_ENC_WAIT;
         end
         S_ENC_WAIT: begin
            if (core_ready && r_pulse_old) begin
               w_capture   = 1'b1;
               w_state_nxt = S_WR;
            end
         end
         S_WR: begin
            mem_wr_req = !r_gap;
            if (mem_wr_ack && !r_gap) begin
               w_wr_acc = 1'b1;
               if (w_last_word) w_state_nxt = (w_blk_inc == r_num_blocks) ? S_DONE : S_RD;
            end
         end
         S_DONE: begin
            busy        = 1'b0;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge aes_clk) begin
      if (aes_rst) begin
         r_num_blocks  <= '0;
         r_blocks_done <= '0;
         r_rd_base     <= '0;
         r_wr_base     <= '0;
         r_rd_off      <= '0;
         r_wr_off      <= '0;
         r_word        <= '0;
         r_gap         <= 1'b0;
         r_pulse_old   <= 1'b0;
         r_last_result <= '0;
      end else begin
         r_gap       <= w_rd_acc | w_wr_acc;
         r_pulse_old <= !(core_init | core_next);
         if (w_start) begin
            r_num_blocks  <= num_blocks;
            r_blocks_done <= '0;
            r_rd_base     <= rd_addr_start;
            r_wr_base     <= wr_addr_start;
            r_rd_off      <= '0;
            r_wr_off      <= '0;
            r_word        <= '0;
         end
         if (w_rd_acc || w_wr_acc) r_word <= w_last_word ? 2'd0 : r_word + 2'd1;
         if (w_rd_acc) r_rd_off <= r_rd_off + ADDR_W'(BYTES);
         if (w_wr_acc) begin
            r_wr_off <= r_wr_off + ADDR_W'(BYTES);
            if (w_last_word) r_blocks_done <= w_blk_inc;
         end
         if (w_capture) r_last_result <= core_result;
      end
   end

   aes_blk_pack #(.BUS_W(BUS_W)) u_pack (
      .i_clk       (aes_clk),
      .i_rst       (aes_rst),
      .i_load      (w_capture),
      .i_load_blk  (core_result),
      .i_shift_in  (w_rd_acc),
      .i_word_in   (mem_rd_data),
      .i_shift_out (w_wr_acc),
      .o_word_out  (mem_wr_data),
      .o_blk       (w_blk)
   );

`ifdef AES_STREAM_CBC_EN
   logic         r_mode;
   logic [127:0] r_chain;

   always_ff @(posedge aes_clk) begin
      if (aes_rst) begin
         r_mode  <= 1'b0;
         r_chain <= '0;
      end else begin
         if (w_start) begin
            r_mode  <= mode;
            r_chain <= iv;
         end
         if (w_capture && r_mode) r_chain <= core_result;
      end
   end

   assign core_block = r_mode ? (w_blk ^ r_chain) : w_blk;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{mode, iv};
   assign core_block   = w_blk;
`endif

   // Offsets are kept modulo 2^ADDR_W so the sums wrap silently.
   assign mem_rd_addr = r_rd_base + r_rd_off;
   assign mem_wr_addr = r_wr_base + r_wr_off;
   assign blocks_done = r_blocks_done;
   assign last_result = r_last_result;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
module tb_aes_stream_ctrl;

   localparam logic [127:0] PT_KAT = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] CT_KAT = 128'h8ea2b7ca_516745bf_eafc4990_4b496089;

   logic          aes_clk, aes_rst, start, mode;
   logic [31:0]   num_blocks, rd_addr_start, wr_addr_start;
   logic [127:0]  iv;
   logic          mem_rd_req, mem_rd_ack, mem_wr_req, mem_wr_ack;
   logic [31:0]   mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
   logic          core_init, core_next, core_ready;
   logic [127:0]  core_block, core_result;
   logic          busy, done;
   logic [31:0]   blocks_done;
   logic [127:0]  last_result;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] rd_mem [logic [31:0]];
   logic [31:0] rd_log[$];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   int          init_cnt, next_cnt, stab_err, gap_err;
   bit          lat_rand = 0;

   aes_stream_ctrl dut (
      .aes_clk(aes_clk), .aes_rst(aes_rst), .start(start), .num_blocks(num_blocks),
      .rd_addr_start(rd_addr_start), .wr_addr_start(wr_addr_start), .mode(mode), .iv(iv),
      .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_rd_ack(mem_rd_ack),
      .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
      .core_init(core_init), .core_next(core_next), .core_ready(core_ready),
      .core_block(core_block), .core_result(core_result),
      .busy(busy), .done(done), .blocks_done(blocks_done), .last_result(last_result)
   );

   initial begin
      aes_clk = 1'b0;
      forever #5 aes_clk = ~aes_clk;
   end

   // Stand-in cipher: the known AES-256 vector, otherwise a fixed permutation.
   function automatic logic [127:0] core_model(input logic [127:0] b);
      if (b == PT_KAT) return CT_KAT;
      return {b[119:0], b[127:120]} ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
   endfunction

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (rd_mem.exists(a)) return rd_mem[a];
      return a ^ 32'h5ac3_3c5a;
   endfunction

   function automatic logic [127:0] src_blk(input logic [31:0] base, input int b);
      logic [31:0] a;
      a = base + 32'(b * 16);
      return {rd_word(a), rd_word(a + 32'd4), rd_word(a + 32'd8), rd_word(a + 32'd12)};
   endfunction

   // Core model: ready drops the cycle after a pulse, result appears ~3 cycles later.
   initial begin : core_proc
      bit           pend;
      int           cnt;
      logic [127:0] res;
      core_ready = 1'b1; core_result = '0; pend = 0; cnt = 0; res = '0;
      forever begin
         @(negedge aes_clk);
         if (pend) begin
            core_ready = 1'b0; cnt = 2; pend = 0;
         end else if (!core_ready) begin
            if (cnt == 0) begin core_ready = 1'b1; core_result = res; end
            else cnt--;
         end
         if (core_init) begin pend = 1; init_cnt++; res = '0; end
         if (core_next) begin pend = 1; next_cnt++; res = core_model(core_block); end
      end
   end

   initial begin : rd_resp
      int lat; bit p_req, p_ack; logic [31:0] p_addr;
      mem_rd_ack = 1'b0; mem_rd_data = '0; lat = 0; p_req = 0; p_ack = 0; p_addr = '0;
      forever begin
         @(negedge aes_clk);
         if (mem_rd_req && p_req && !p_ack && mem_rd_addr !== p_addr) stab_err++;
         if (mem_rd_req && p_ack) gap_err++;
         mem_rd_ack = 1'b0;
         if (mem_rd_req) begin
            if (lat == 0) begin
               mem_rd_ack = 1'b1; mem_rd_data = rd_word(mem_rd_addr);
               rd_log.push_back(mem_rd_addr);
               lat = lat_rand ? int'($urandom_range(5, 0)) : 0;
            end else lat--;
         end
         p_req = mem_rd_req; p_addr = mem_rd_addr; p_ack = mem_rd_ack;
      end
   end

   initial begin : wr_resp
      int lat; bit p_req, p_ack; logic [31:0] p_addr, p_data;
      mem_wr_ack = 1'b0; lat = 0; p_req = 0; p_ack = 0; p_addr = '0; p_data = '0;
      forever begin
         @(negedge aes_clk);
         if (mem_wr_req && p_req && !p_ack && (mem_wr_addr !== p_addr || mem_wr_data !== p_data)) stab_err++;
         if (mem_wr_req && p_ack) gap_err++;
         mem_wr_ack = 1'b0;
         if (mem_wr_req) begin
            if (lat == 0) begin
               mem_wr_ack = 1'b1;
               wr_addr_log.push_back(mem_wr_addr); wr_data_log.push_back(mem_wr_data);
               lat = lat_rand ? int'($urandom_range(5, 0)) : 0;
            end else lat--;
         end
         p_req = mem_wr_req; p_addr = mem_wr_addr; p_data = mem_wr_data; p_ack = mem_wr_ack;
      end
   end

   task automatic kick(input logic [31:0] nb, input logic [31:0] rb, input logic [31:0] wb,
                       input logic md, input logic [127:0] ivv);
      rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
      init_cnt = 0; next_cnt = 0; stab_err = 0; gap_err = 0;
      @(negedge aes_clk);
      num_blocks = nb; rd_addr_start = rb; wr_addr_start = wb; mode = md; iv = ivv; start = 1'b1;
      @(negedge aes_clk);
      start = 1'b0;
   endtask

   // Issues a job and waits (bounded) until done has pulsed and busy is low.
   task automatic run_op(input logic [31:0] nb, input logic [31:0] rb, input logic [31:0] wb,
                         input logic md, input logic [127:0] ivv,
                         output int dcnt, output int first_done, output bit tmo);
      kick(nb, rb, wb, md, ivv);
      dcnt = 0; first_done = -1; tmo = 1;
      for (int c = 0; c < 3000; c++) begin
         if (done) begin
            if (dcnt == 0) first_done = c;
            dcnt++;
         end else if (dcnt > 0 && !busy) begin
            tmo = 0;
            break;
         end
         @(negedge aes_clk);
      end
   endtask

   task automatic test_reset;
      aes_rst = 1'b1;
      repeat (3) @(negedge aes_clk);
      n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_vec++; if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
      n_vec++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL reset_rd_req got=%b want=0", mem_rd_req); end
      n_vec++; if (mem_wr_req !== 1'b0) begin n_err++; $display("FAIL reset_wr_req got=%b want=0", mem_wr_req); end
      n_vec++; if (core_init !== 1'b0)  begin n_err++; $display("FAIL reset_core_init got=%b want=0", core_init); end
      n_vec++; if (core_next !== 1'b0)  begin n_err++; $display("FAIL reset_core_next got=%b want=0", core_next); end
      n_vec++; if (blocks_done !== 32'd0) begin n_err++; $display("FAIL reset_blocks_done got=%0d want=0", blocks_done); end
      n_vec++; if (last_result !== 128'd0) begin n_err++; $display("FAIL reset_last_result got=%h want=0", last_result); end
      aes_rst = 1'b0;
   endtask

   task automatic test_kat;
      int dcnt, fd; bit tmo;
      logic [31:0] exp_d [4];
      exp_d[0] = 32'h8ea2b7ca; exp_d[1] = 32'h516745bf; exp_d[2] = 32'heafc4990; exp_d[3] = 32'h4b496089;
      rd_mem[32'h1000] = 32'h00112233; rd_mem[32'h1004] = 32'h44556677;
      rd_mem[32'h1008] = 32'h8899aabb; rd_mem[32'h100c] = 32'hccddeeff;
      run_op(32'd1, 32'h1000, 32'h2000, 1'b0, '0, dcnt, fd, tmo);
      n_vec++; if (tmo) begin n_err++; $display("FAIL kat_timeout got=timeout want=completion"); end
      n_vec++; if (dcnt != 1) begin n_err++; $display("FAIL kat_done_pulses got=%0d want=1", dcnt); end
      n_vec++; if (wr_addr_log.size() != 4) begin n_err++; $display("FAIL kat_wr_count got=%0d want=4", wr_addr_log.size()); end
      for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
         n_vec++; if (wr_addr_log[i] !== 32'h2000 + 32'(4 * i)) begin n_err++; $display("FAIL kat_wr_addr[%0d] got=%h want=%h", i, wr_addr_log[i], 32'h2000 + 32'(4 * i)); end
         n_vec++; if (wr_data_log[i] !== exp_d[i]) begin n_err++; $display("FAIL kat_wr_data[%0d] got=%h want=%h", i, wr_data_log[i], exp_d[i]); end
      end
      for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
         n_vec++; if (rd_log[i] !== 32'h1000 + 32'(4 * i)) begin n_err++; $display("FAIL kat_rd_addr[%0d] got=%h want=%h", i, rd_log[i], 32'h1000 + 32'(4 * i)); end
      end
      n_vec++; if (blocks_done !== 32'd1) begin n_err++; $display("FAIL kat_blocks_done got=%0d want=1", blocks_done); end
      n_vec++; if (last_result !== CT_KAT) begin n_err++; $display("FAIL kat_last_result got=%h want=%h", last_result, CT_KAT); end
   endtask

   task automatic test_zero_blocks;
      int dcnt, fd; bit tmo;
      run_op(32'd0, 32'h1000, 32'h2000, 1'b0, '0, dcnt, fd, tmo);
      n_vec++; if (tmo) begin n_err++; $display("FAIL zero_timeout got=timeout want=completion"); end
      n_vec++; if (dcnt != 1) begin n_err++; $display("FAIL zero_done_pulses got=%0d want=1", dcnt); end
      n_vec++; if (fd != 0) begin n_err++; $display("FAIL zero_done_latency got=%0d want=0", fd); end
      n_vec++; if (rd_log.size() + wr_addr_log.size() != 0) begin n_err++; $display("FAIL zero_mem_traffic got=%0d want=0", rd_log.size() + wr_addr_log.size()); end
      n_vec++; if (init_cnt + next_cnt != 0) begin n_err++; $display("FAIL zero_core_traffic got=%0d want=0", init_cnt + next_cnt); end
      n_vec++; if (blocks_done !== 32'd0) begin n_err++; $display("FAIL zero_blocks_done got=%0d want=0", blocks_done); end
   endtask

   task automatic test_back_to_back_latency;
      int dcnt, fd; bit tmo;
      logic [127:0] pt, ct;
      logic [31:0]  exp_w;
      pt = 128'h01234567_89abcdef_fedcba98_76543210;
      ct = core_model(pt);
      for (int b = 0; b < 3; b++)
         for (int w = 0; w < 4; w++) rd_mem[32'h3000 + 32'(16 * b + 4 * w)] = pt[127 - 32 * w -: 32];
      lat_rand = 1;
      run_op(32'd3, 32'h3000, 32'h5000, 1'b0, '0, dcnt, fd, tmo);
      lat_rand = 0;
      n_vec++; if (tmo) begin n_err++; $display("FAIL b2b_timeout got=timeout want=completion"); end
      n_vec++; if (dcnt != 1) begin n_err++; $display("FAIL b2b_done_pulses got=%0d want=1", dcnt); end
      n_vec++; if (wr_addr_log.size() != 12) begin n_err++; $display("FAIL b2b_wr_count got=%0d want=12", wr_addr_log.size()); end
      for (int i = 0; i < 12 && i < wr_addr_log.size(); i++) begin
         exp_w = ct[127 - 32 * (i % 4) -: 32];
         n_vec++; if (wr_addr_log[i] !== 32'h5000 + 32'(4 * i)) begin n_err++; $display("FAIL b2b_wr_addr[%0d] got=%h want=%h", i, wr_addr_log[i], 32'h5000 + 32'(4 * i)); end
         n_vec++; if (wr_data_log[i] !== exp_w) begin n_err++; $display("FAIL b2b_wr_data[%0d] got=%h want=%h", i, wr_data_log[i], exp_w); end
      end
      n_vec++; if (blocks_done !== 32'd3) begin n_err++; $display("FAIL b2b_blocks_done got=%0d want=3", blocks_done); end
      n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL b2b_req_stable got=%0d changes want=0", stab_err); end
      n_vec++; if (gap_err != 0) begin n_err++; $display("FAIL b2b_req_gap got=%0d violations want=0", gap_err); end
      n_vec++; if (init_cnt != 1) begin n_err++; $display("FAIL b2b_key_inits got=%0d want=1", init_cnt); end
      n_vec++; if (next_cnt != 3) begin n_err++; $display("FAIL b2b_core_next got=%0d want=3", next_cnt); end
   endtask

   task automatic test_wrap;
      int dcnt, fd; bit tmo;
      logic [31:0] exp_ra [4];
      logic [31:0] exp_wa [4];
      exp_ra[0] = 32'hfffffff8; exp_ra[1] = 32'hfffffffc; exp_ra[2] = 32'h00000000; exp_ra[3] = 32'h00000004;
      exp_wa[0] = 32'hfffffff4; exp_wa[1] = 32'hfffffff8; exp_wa[2] = 32'hfffffffc; exp_wa[3] = 32'h00000000;
      run_op(32'd1, 32'hfffffff8, 32'hfffffff4, 1'b0, '0, dcnt, fd, tmo);
      n_vec++; if (tmo) begin n_err++; $display("FAIL wrap_timeout got=timeout want=completion"); end
      n_vec++; if (rd_log.size() != 4 || wr_addr_log.size() != 4) begin n_err++; $display("FAIL wrap_counts got=%0d/%0d want=4/4", rd_log.size(), wr_addr_log.size()); end
      for (int i = 0; i < 4 && i < rd_log.size() && i < wr_addr_log.size(); i++) begin
         n_vec++; if (rd_log[i] !== exp_ra[i]) begin n_err++; $display("FAIL wrap_rd_addr[%0d] got=%h want=%h", i, rd_log[i], exp_ra[i]); end
         n_vec++; if (wr_addr_log[i] !== exp_wa[i]) begin n_err++; $display("FAIL wrap_wr_addr[%0d] got=%h want=%h", i, wr_addr_log[i], exp_wa[i]); end
      end
      n_vec++; if (last_result !== core_model(src_blk(32'hfffffff8, 0))) begin n_err++; $display("FAIL wrap_result got=%h want=%h", last_result, core_model(src_blk(32'hfffffff8, 0))); end
   endtask

   // With chaining built, block 2 must be cipher(pt2 ^ ct1); without it,
   // mode/iv must be ignored and both blocks are plain ECB.
   task automatic test_mode;
      int dcnt, fd; bit tmo;
      logic [127:0] ivv, ct1, ct2, got2;
      logic [127:0] pt1, pt2;
      pt1 = src_blk(32'h4000, 0);
      pt2 = src_blk(32'h4000, 1);
`ifdef AES_STREAM_CBC_EN
      ivv = '0;
      ct1 = core_model(pt1 ^ ivv);
      ct2 = core_model(pt2 ^ ct1);
`else
      ivv = 128'hffff0000_ffff0000_ffff0000_ffff0000;
      ct1 = core_model(pt1);
      ct2 = core_model(pt2);
`endif
      run_op(32'd2, 32'h4000, 32'h6000, 1'b1, ivv, dcnt, fd, tmo);
      n_vec++; if (tmo) begin n_err++; $display("FAIL mode_timeout got=timeout want=completion"); end
      n_vec++; if (wr_data_log.size() != 8) begin n_err++; $display("FAIL mode_wr_count got=%0d want=8", wr_data_log.size()); end
      if (wr_data_log.size() == 8) begin
         n_vec++; if ({wr_data_log[0], wr_data_log[1], wr_data_log[2], wr_data_log[3]} !== ct1) begin n_err++; $display("FAIL mode_block1 got=%h want=%h", {wr_data_log[0], wr_data_log[1], wr_data_log[2], wr_data_log[3]}, ct1); end
         got2 = {wr_data_log[4], wr_data_log[5], wr_data_log[6], wr_data_log[7]};
         n_vec++; if (got2 !== ct2) begin n_err++; $display("FAIL mode_block2 got=%h want=%h", got2, ct2); end
      end
      n_vec++; if (last_result !== ct2) begin n_err++; $display("FAIL mode_last_result got=%h want=%h", last_result, ct2); end
   endtask

   task automatic test_reset_mid;
      int dcnt, fd; bit tmo, found;
      kick(32'd2, 32'h3000, 32'h7000, 1'b0, '0);
      found = 0;
      for (int c = 0; c < 3000 && !found; c++) begin
         @(negedge aes_clk);
         if (mem_wr_req && blocks_done == 32'd1) found = 1;
      end
      n_vec++; if (!found) begin n_err++; $display("FAIL midrst_reach_wr2 got=timeout want=block2 write"); end
      aes_rst = 1'b1;
      @(negedge aes_clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
      n_vec++; if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin n_err++; $display("FAIL midrst_req got=%b%b want=00", mem_rd_req, mem_wr_req); end
      n_vec++; if (blocks_done !== 32'd0) begin n_err++; $display("FAIL midrst_blocks_done got=%0d want=0", blocks_done); end
      aes_rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge aes_clk);
         n_vec++; if (mem_rd_req || mem_wr_req || busy) begin n_err++; $display("FAIL midrst_idle[%0d] got=%b%b%b want=000", c, mem_rd_req, mem_wr_req, busy); end
      end
      run_op(32'd1, 32'h1000, 32'h2000, 1'b0, '0, dcnt, fd, tmo);
      n_vec++; if (tmo || dcnt != 1) begin n_err++; $display("FAIL midrst_rerun got=tmo%0d/done%0d want=tmo0/done1", tmo, dcnt); end
      n_vec++; if (wr_data_log.size() != 4 || wr_data_log[0] !== 32'h8ea2b7ca) begin n_err++; $display("FAIL midrst_rerun_data got=%0d words want=4 starting 8ea2b7ca", wr_data_log.size()); end
      n_vec++; if (last_result !== CT_KAT) begin n_err++; $display("FAIL midrst_rerun_result got=%h want=%h", last_result, CT_KAT); end
   endtask

   initial begin
      aes_rst = 1'b1; start = 1'b0; mode = 1'b0; iv = '0;
      num_blocks = '0; rd_addr_start = '0; wr_addr_start = '0;
      test_reset();
      test_kat();
      test_zero_blocks();
      test_back_to_back_latency();
      test_wrap();
      test_mode();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
